conv_line_feeder: RTL and testbench
===================================

Name: conv_line_feeder

Overview:
- Producer-side sequencer for one 5-tap convolution line. It loads the K tap weights, then streams accepted input pixels as x/w/psum operands into the PE line.
- It generates a valid strobe delayed to match the PE line's pipeline latency, so downstream logic knows when the saturated line output is meaningful.
- Sits between the activation/weight buffers and the convolution line.

Parameters:
- I_X, 8, pixel (activation) width, signed
- I_W, 8, weight width, signed
- I_PSUM, 16, partial-sum width driven into the line, signed
- K, 5, taps per line; also the line's pipeline latency in cycles
- IMG_W, 32, pixels per image row streamed per run

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle run request
- i_w_valid  in  1  weight word valid
- i_w_data  in  I_W  weight word, signed
- o_w_ready  out  1  feeder accepts weight word
- i_x_valid  in  1  pixel valid
- i_x_data  in  I_X  pixel, signed
- o_x_ready  out  1  feeder accepts pixel
- o_x  out  I_X  pixel operand to line
- o_w  out  I_W  weight operand to line
- o_psum  out  I_PSUM  initial partial sum to line
- o_psum_valid  out  1  line output valid, K cycles after operand issue
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM in IDLE; all counters 0; weight registers 0.
  - o_x, o_w and o_psum are 0.
  - o_w_ready, o_x_ready, o_psum_valid, o_busy and o_done are 0.
  - The valid shift register is cleared.
- FSM states: IDLE, LOAD_W, RUN, DRAIN, DONE.
- IDLE:
  - i_start=1 -> LOAD_W.
  - i_start is ignored in every other state.
- LOAD_W:
  - o_w_ready=1.
  - Each cycle with i_w_valid&&o_w_ready, write i_w_data into weight[widx] and increment widx.
  - After the handshake with widx==K-1 (K words total): widx clears -> RUN.
- RUN:
  - o_x_ready=1.
  - On an i_x_valid&&o_x_ready handshake, register the next cycle's outputs:
    - o_x=i_x_data
    - o_w=weight[tap]
    - o_psum=0, or the bias when BIAS_EN is defined
  - Then tap advances 0..K-1 and wraps to 0; col increments.
  - Without a handshake, o_x/o_w/o_psum hold their last values and a 0 enters the valid pipe.
  - After the handshake with col==IMG_W-1: col and tap clear -> DRAIN.
- Valid pipe:
  - K-deep shift register; a 1 is inserted on each RUN handshake.
  - o_psum_valid is the last stage, so it rises exactly K cycles after the operands appear on o_x/o_w.
- DRAIN:
  - o_x_ready=0; the drain counter counts K cycles, shifting 0s into the pipe.
  - At count K-1 -> DONE.
- DONE:
  - o_done=1 for one cycle -> IDLE.
- o_busy=1 in LOAD_W, RUN, DRAIN and DONE.
- Simultaneous valid without ready:
  - A word is never consumed, and no counter moves.
- Reset mid-run:
  - Immediate return to IDLE; weights cleared; no o_done.
  - In-flight valids are discarded.
- Widths:
  - Operands pass through unmodified.
  - The bias is sign-extended from I_W to I_PSUM.

Optional Feature:
- Macro: CONV_LINE_FEEDER_BIAS_EN.
- Defined:
  - LOAD_W accepts K+1 words; the final word is stored as the bias.
  - o_psum = sign-extended bias on every RUN handshake.
- Undefined:
  - LOAD_W accepts exactly K words; o_psum is constant 0.
  - No bias register exists.

Decomposition:
- Shared package (conv_pkg):
  - FSM state enum (IDLE, LOAD_W, RUN, DRAIN, DONE).
  - Default widths I_X, I_W and I_PSUM.
  - Tap count K.
- Natural sub-module: conv_valid_delay, a K-deep parameterised valid shift register with async active-low clear.
- The weight register file and FSM stay in the top.

Test Plan:
- Load weights {1,2,3,4,5} with continuous valid:
  - 5 handshakes, then RUN.
  - The first pixel 10 appears as o_x=10, o_w=1.
  - o_psum_valid rises 5 cycles later.
- Stream 32 pixels with i_x_valid toggling every other cycle:
  - Exactly 32 o_psum_valid pulses; tap sequence 1,2,3,4,5,1,…
  - o_done pulses 5 cycles after the last valid strobe enters the pipe.
- Hold i_w_valid=0 for 7 cycles during LOAD_W:
  - FSM remains in LOAD_W; widx is unchanged.
  - Stored weights are unaffected.
- Assert i_rst_n=0 at pixel 17:
  - All outputs 0 asynchronously; FSM back in IDLE.
  - No o_done; the next i_start begins a fresh LOAD_W.
- Pulse i_start during RUN:
  - Ignored; the run completes normally with 32 valids.
- With CONV_LINE_FEEDER_BIAS_EN defined, load {1,2,3,4,5,-3}:
  - o_psum=0xFFFD on every RUN handshake.
  - With the macro undefined, o_psum=0 throughout.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution line feeder.
//   - default operand widths (pixel, weight, partial sum)
//   - tap count of one convolution line and default row length
//   - feeder FSM state encoding
package conv_pkg;

   localparam int unsigned CONV_I_X    = 8;
   localparam int unsigned CONV_I_W    = 8;
   localparam int unsigned CONV_I_PSUM = 16;
   localparam int unsigned CONV_K      = 5;
   localparam int unsigned CONV_IMG_W  = 32;

   typedef enum logic [2:0] {
      StIdle,
      StLoadW,
      StRun,
      StDrain,
      StDone
   } feeder_state_e;

endpackage

// File: rtl/conv_valid_delay.sv
// Fixed-depth valid strobe delay line.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low clear of every stage
//   i_valid  strobe entering stage 0
//   o_valid  strobe leaving the last stage, DEPTH cycles later
module conv_valid_delay #(
   parameter int unsigned DEPTH = 5
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_valid,
   output logic o_valid
);

   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = i_valid;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign o_valid = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_line_feeder.sv
// Producer-side sequencer for one K-tap convolution line.
// Loads K tap weights, then streams IMG_W accepted pixels as x/w/psum operands,
// with a valid strobe delayed K cycles to match the line's pipeline latency.
// Optional feature: define CONV_LINE_FEEDER_BIAS_EN to load one extra weight
// word as a bias, driven sign-extended on o_psum; otherwise o_psum is 0.
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_start                 single-cycle run request (honoured in IDLE only)
//   i_w_valid/i_w_data      weight stream in, o_w_ready accept
//   i_x_valid/i_x_data      pixel stream in, o_x_ready accept
//   o_x, o_w, o_psum        registered operands to the PE line
//   o_psum_valid            line output valid, K cycles after operand issue
//   o_busy                  high outside IDLE
//   o_done                  one-cycle pulse at end of run
module conv_line_feeder
   import conv_pkg::*;
#(
   parameter int unsigned I_X    = CONV_I_X,
   parameter int unsigned I_W    = CONV_I_W,
   parameter int unsigned I_PSUM = CONV_I_PSUM,
   parameter int unsigned K      = CONV_K,
   parameter int unsigned IMG_W  = CONV_IMG_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_w_valid,
   input  logic [I_W-1:0]    i_w_data,
   output logic              o_w_ready,
   input  logic              i_x_valid,
   input  logic [I_X-1:0]    i_x_data,
   output logic              o_x_ready,
   output logic [I_X-1:0]    o_x,
   output logic [I_W-1:0]    o_w,
   output logic [I_PSUM-1:0] o_psum,
   output logic              o_psum_valid,
   output logic              o_busy,
   output logic              o_done
);

`ifdef CONV_LINE_FEEDER_BIAS_EN
   localparam int unsigned NUM_W = K + 1;
`else
   localparam int unsigned NUM_W = K;
`endif
   localparam int unsigned WIDX_W = $clog2(NUM_W + 1);
   localparam int unsigned TAP_W  = $clog2(K + 1);
   localparam int unsigned COL_W  = $clog2(IMG_W + 1);

   feeder_state_e     state_q, state_d;
   logic [WIDX_W-1:0] widx_q, widx_d;
   logic [TAP_W-1:0]  tap_q, tap_d;
   logic [TAP_W-1:0]  drain_q, drain_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [I_W-1:0]    weight_q [K];
   logic [I_W-1:0]    weight_d [K];
   logic [I_X-1:0]    x_q, x_d;
   logic [I_W-1:0]    w_q, w_d;
   // High in the cycle the operands of a handshake are on o_x/o_w.
   logic              issue_q, issue_d;
`ifdef CONV_LINE_FEEDER_BIAS_EN
   logic [I_W-1:0]    bias_q, bias_d;
   logic [I_PSUM-1:0] psum_q, psum_d;
`endif

   always_comb begin
      state_d  = state_q;
      widx_d   = widx_q;
      tap_d    = tap_q;
      drain_d  = drain_q;
      col_d    = col_q;
      weight_d = weight_q;
      x_d      = x_q;
      w_d      = w_q;
      issue_d  = 1'b0;
`ifdef CONV_LINE_FEEDER_BIAS_EN
      bias_d   = bias_q;
      psum_d   = psum_q;
`endif

      case (state_q)
         StIdle: begin
            if (i_start) begin
               widx_d  = '0;
               state_d = StLoadW;
            end
         end

         StLoadW: begin
            if (i_w_valid) begin
               for (int i = 0; i < K; i++) begin
                  if (widx_q == WIDX_W'(i)) begin
                     weight_d[i] = i_w_data;
                  end
               end
`ifdef CONV_LINE_FEEDER_BIAS_EN
               if (widx_q == WIDX_W'(K)) begin
                  bias_d = i_w_data;
               end
`endif
               if (widx_q == WIDX_W'(NUM_W - 1)) begin
                  widx_d  = '0;
                  tap_d   = '0;
                  col_d   = '0;
                  state_d = StRun;
               end else begin
                  widx_d = widx_q + 1'b1;
               end
            end
         end

         StRun: begin
            if (i_x_valid) begin
               x_d     = i_x_data;
               w_d     = weight_q[tap_q];
               issue_d = 1'b1;
`ifdef CONV_LINE_FEEDER_BIAS_EN
               psum_d  = I_PSUM'($signed(bias_q));
`endif
               tap_d = (tap_q == TAP_W'(K - 1)) ? '0 : tap_q + 1'b1;
               if (col_q == COL_W'(IMG_W - 1)) begin
                  col_d   = '0;
                  tap_d   = '0;
                  drain_d = '0;
                  state_d = StDrain;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end

         StDrain: begin
            // K cycles let the last issued strobe reach o_psum_valid.
            if (drain_q == TAP_W'(K - 1)) begin
               drain_d = '0;
               state_d = StDone;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         widx_q  <= '0;
         tap_q   <= '0;
         drain_q <= '0;
         col_q   <= '0;
         x_q     <= '0;
         w_q     <= '0;
         issue_q <= 1'b0;
         for (int i = 0; i < K; i++) begin
            weight_q[i] <= '0;
         end
`ifdef CONV_LINE_FEEDER_BIAS_EN
         bias_q  <= '0;
         psum_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         widx_q   <= widx_d;
         tap_q    <= tap_d;
         drain_q  <= drain_d;
         col_q    <= col_d;
         x_q      <= x_d;
         w_q      <= w_d;
         issue_q  <= issue_d;
         weight_q <= weight_d;
`ifdef CONV_LINE_FEEDER_BIAS_EN
         bias_q   <= bias_d;
         psum_q   <= psum_d;
`endif
      end
   end

   conv_valid_delay #(
      .DEPTH (K)
   ) u_valid_delay (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (issue_q),
      .o_valid (o_psum_valid)
   );

   assign o_w_ready = (state_q == StLoadW);
   assign o_x_ready = (state_q == StRun);
   assign o_busy    = (state_q != StIdle);
   assign o_done    = (state_q == StDone);
   assign o_x       = x_q;
   assign o_w       = w_q;
`ifdef CONV_LINE_FEEDER_BIAS_EN
   assign o_psum    = psum_q;
`else
   assign o_psum    = '0;
`endif

endmodule

// File: tb/tb_conv_line_feeder.sv
// Self-checking bench for conv_line_feeder: randomized stimulus, a phase-level
// reference model, and a scoreboard popped by an independent output monitor.
module tb_conv_line_feeder;

   localparam int K     = 5;
   localparam int IMG_W = 32;
`ifdef CONV_LINE_FEEDER_BIAS_EN
   localparam int NUM_W = K + 1;
`else
   localparam int NUM_W = K;
`endif

   typedef struct packed {
      logic [7:0]  x;
      logic [7:0]  w;
      logic [15:0] p;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start, i_w_valid, i_x_valid;
   logic [7:0]  i_w_data, i_x_data;
   logic        o_w_ready, o_x_ready, o_psum_valid, o_busy, o_done;
   logic [7:0]  o_x, o_w;
   logic [15:0] o_psum;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;

   // Reference model: 0 idle, 1 load weights, 2 run, 3 drain, 4 done.
   int         m_phase, m_widx, m_tap, m_col, m_cnt;
   logic [7:0] m_w [K];
   logic [7:0] m_bias;
   bit         m_w_acc;
   exp_t       exp_q[$];

   conv_line_feeder dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_w_valid    (i_w_valid),
      .i_w_data     (i_w_data),
      .o_w_ready    (o_w_ready),
      .i_x_valid    (i_x_valid),
      .i_x_data     (i_x_data),
      .o_x_ready    (o_x_ready),
      .o_x          (o_x),
      .o_w          (o_w),
      .o_psum       (o_psum),
      .o_psum_valid (o_psum_valid),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_widx = 0; m_tap = 0; m_col = 0; m_cnt = 0; m_bias = '0;
      for (int i = 0; i < K; i++) m_w[i] = '0;
      exp_q.delete();
   endtask

   task automatic check_ctrl();
      chk("w_ready", 32'(o_w_ready), 32'(m_phase == 1));
      chk("x_ready", 32'(o_x_ready), 32'(m_phase == 2));
      chk("busy",    32'(o_busy),    32'(m_phase != 0));
      chk("done",    32'(o_done),    32'(m_phase == 4));
   endtask

   task automatic check_all_zero();
      chk("rst_o_x", 32'(o_x), 0);
      chk("rst_o_w", 32'(o_w), 0);
      chk("rst_o_psum", 32'(o_psum), 0);
      chk("rst_psum_valid", 32'(o_psum_valid), 0);
      chk("rst_w_ready", 32'(o_w_ready), 0);
      chk("rst_x_ready", 32'(o_x_ready), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
   endtask

   // Applies the rules to the inputs seen at a rising edge.
   task automatic model_update();
      exp_t e;
      m_w_acc = 0;
      if (!i_rst_n) return;
      case (m_phase)
         0: if (i_start) begin m_phase = 1; m_widx = 0; end
         1: if (i_w_valid) begin
               if (m_widx < K) m_w[m_widx] = i_w_data;
               else m_bias = i_w_data;
               m_widx++;
               m_w_acc = 1;
               if (m_widx == NUM_W) begin m_phase = 2; m_tap = 0; m_col = 0; end
            end
         2: if (i_x_valid) begin
               e.x = i_x_data;
               e.w = m_w[m_tap];
`ifdef CONV_LINE_FEEDER_BIAS_EN
               e.p = 16'($signed(m_bias));
`else
               e.p = 16'd0;
`endif
               exp_q.push_back(e);
               m_tap = (m_tap + 1) % K;
               m_col++;
               if (m_col == IMG_W) begin m_phase = 3; m_cnt = 0; end
            end
         3: begin
               m_cnt++;
               if (m_cnt == K) m_phase = 4;
            end
         default: m_phase = 0;
      endcase
   endtask

   // Called at a falling edge: drive, clock once, then check at the next falling edge.
   task automatic cycle(input logic st, input logic wv, input logic [7:0] wd,
                        input logic xv, input logic [7:0] xd);
      i_start = st; i_w_valid = wv; i_w_data = wd; i_x_valid = xv; i_x_data = xd;
      @(posedge i_clk);
      model_update();
      @(negedge i_clk);
      check_ctrl();
   endtask

   // mode 0: fixed weights, toggling pixel valid, start pulse mid-run
   // mode 1: random weights with a 7-cycle weight gap, random pixel valid
   // mode 2: random everything; rst_at>0 resets after that many pixels
   task automatic do_run(input int mode, input int rst_at);
      logic [7:0] wv [NUM_W];
      int j, gap, guard;
      logic v, xv;
      logic [7:0] xd;
      for (int i = 0; i < NUM_W; i++) wv[i] = (mode == 0) ? 8'(i + 1) : 8'($urandom);
`ifdef CONV_LINE_FEEDER_BIAS_EN
      if (mode == 0) wv[K] = 8'hFD;
`endif
      n_valid = 0;
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      j = 0; gap = 0; guard = 0;
      while (m_phase == 1 && guard < 200) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1 && j == 2 && gap < 7) begin v = 1'b0; gap++; end
         else v = 1'($urandom_range(0, 1));
         cycle(1'b0, v, wv[j], 1'b0, 8'h00);
         if (m_w_acc) j++;
         guard++;
      end
      if (m_phase == 1) chk("load_timeout", 1, 0);
      guard = 0;
      while (m_phase != 0 && guard < 600) begin
         if (rst_at > 0 && m_phase == 2 && m_col == rst_at) begin
            #2 i_rst_n = 1'b0;
            #1 check_all_zero();
            model_reset();
            n_valid = 0;
            @(negedge i_clk);
            check_ctrl();
            i_start = 0; i_w_valid = 0; i_x_valid = 0;
            i_rst_n = 1'b1;
            for (int c = 0; c < 2 * K; c++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'($urandom));
            chk("no_valid_after_reset", 32'(n_valid), 0);
            return;
         end
         xv = (mode == 0) ? 1'(guard % 2) : 1'($urandom_range(0, 1));
         xd = (mode == 0 && m_col == 0) ? 8'd10 : 8'($urandom);
         cycle((mode == 0 && m_col == 8) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
               8'($urandom), xv, xd);
         guard++;
      end
      if (m_phase != 0) chk("run_timeout", 1, 0);
      chk("queue_empty", 32'(exp_q.size()), 0);
      chk("valid_count", 32'(n_valid), IMG_W);
   endtask

   // Output monitor: operands are captured when they appear and compared when
   // their delayed valid strobe arrives K cycles later.
   logic [7:0]  hx [K+1];
   logic [7:0]  hw [K+1];
   logic [15:0] hp [K+1];
   always @(negedge i_clk) begin
      exp_t e;
      for (int i = K; i > 0; i--) begin
         hx[i] = hx[i-1]; hw[i] = hw[i-1]; hp[i] = hp[i-1];
      end
      hx[0] = o_x; hw[0] = o_w; hp[0] = o_psum;
      if (o_psum_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("o_x", 32'(hx[K]), 32'(e.x));
            chk("o_w", 32'(hw[K]), 32'(e.w));
            chk("o_psum", 32'(hp[K]), 32'(e.p));
            n_valid++;
         end
      end
   end

   initial begin
      i_rst_n = 1'b1;
      i_start = 0; i_w_valid = 0; i_w_data = 0; i_x_valid = 0; i_x_data = 0;
      model_reset();
      #1 i_rst_n = 1'b0;
      #2 check_all_zero();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int c = 0; c < 3; c++) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                                        1'($urandom_range(0, 1)), 8'($urandom));
      do_run(0, 0);
      do_run(1, 0);
      do_run(2, 17);
      do_run(2, 0);
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
